// File: rtl/wb_pkg.sv
// Shared types and default widths for the single-transfer Wishbone master.
package wb_pkg;

  localparam int WB_ADDR_WIDTH     = 16;
  localparam int WB_DATA_WIDTH     = 32;
  localparam int WB_GRANULE        = 8;
  localparam int WB_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    IDLE,
    BUS,
    GAP,
    DRAIN,
    RESP
  } wbm_state_t;

endpackage

// File: rtl/wb_watchdog.sv
// Bus-cycle watchdog: counts enabled cycles, flags the last allowed one.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

  // high during the TIMEOUT_CYCLES-th enabled cycle
  assign expired = (cnt == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wb_master_single.sv
// Single-transfer Wishbone B4 master with read-modify-write support.
// Optional bus watchdog enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_single
  import wb_pkg::*;
#(
  parameter  int ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter  int DATA_WIDTH     = WB_DATA_WIDTH,
  parameter  int GRANULE        = WB_GRANULE,
  parameter  int TIMEOUT_CYCLES = WB_TIMEOUT_CYCLES,
  localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_we_i,
  input  logic                  cmd_rmw_i,
  input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
  input  logic [DATA_WIDTH-1:0] cmd_dat_i,
  input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_dat_o,
  output logic                  rsp_err_o,
  output logic                  rsp_timeout_o,
  output logic [ADDR_WIDTH-1:0] adr_o,
  output logic [DATA_WIDTH-1:0] dat_o,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [SEL_WIDTH-1:0]  sel_o,
  output logic                  we_o,
  output logic                  stb_o,
  output logic                  cyc_o,
  input  logic                  ack_i,
  input  logic                  err_i
);

  wbm_state_t            state;
  logic                  rmw_q;
  logic                  timeout_hit;
  logic [DATA_WIDTH-1:0] merged;

  // dat_o still holds the command data during the RMW read phase
  always_comb begin
    merged = dat_o;
    for (int i = 0; i < SEL_WIDTH; i++) begin
      if (!sel_o[i]) begin
        merged[i*GRANULE +: GRANULE] = dat_i[i*GRANULE +: GRANULE];
      end
    end
  end

`ifdef WB_MASTER_TIMEOUT_EN
  logic wd_en;
  logic wd_clear;

  assign wd_en    = (state == BUS);
  assign wd_clear = !wd_en;

  wb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      rmw_q         <= 1'b0;
      cmd_ready_o   <= 1'b1;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
      sel_o         <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_dat_o     <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            cmd_ready_o   <= 1'b0;
            adr_o         <= cmd_adr_i;
            dat_o         <= cmd_dat_i;
            sel_o         <= cmd_sel_i;
            we_o          <= cmd_we_i & ~cmd_rmw_i;
            rmw_q         <= cmd_rmw_i;
            cyc_o         <= 1'b1;
            stb_o         <= 1'b1;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
            state         <= BUS;
          end
        end
        BUS: begin
          if (err_i) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            rsp_err_o <= 1'b1;
            state     <= DRAIN;
          end else if (ack_i) begin
            if (rmw_q) begin
              rsp_dat_o <= dat_i;
              dat_o     <= merged;
              stb_o     <= 1'b0;
              state     <= GAP;
            end else begin
              if (!we_o) begin
                rsp_dat_o <= dat_i;
              end
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
              state <= DRAIN;
            end
          end else if (timeout_hit) begin
            cyc_o         <= 1'b0;
            stb_o         <= 1'b0;
            rsp_err_o     <= 1'b1;
            rsp_timeout_o <= 1'b1;
            state         <= DRAIN;
          end
        end
        GAP: begin
          if (!ack_i && !err_i) begin
            we_o  <= 1'b1;
            stb_o <= 1'b1;
            rmw_q <= 1'b0;
            state <= BUS;
          end
        end
        DRAIN: begin
          if (!ack_i && !err_i) begin
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          cmd_ready_o <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_single.sv
// Directed bench for wb_master_single against a register-file slave.
module tb_wb_master_single;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i, cmd_ready_o;
  logic        cmd_we_i, cmd_rmw_i;
  logic [15:0] cmd_adr_i;
  logic [31:0] cmd_dat_i;
  logic [3:0]  cmd_sel_i;
  logic        rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [31:0] rsp_dat_o;
  logic [15:0] adr_o;
  logic [31:0] dat_o, dat_i;
  logic [3:0]  sel_o;
  logic        we_o, stb_o, cyc_o, ack_i, err_i;

  always #5 clk = ~clk;

  wb_master_single #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32),
    .GRANULE(8), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_we_i(cmd_we_i), .cmd_rmw_i(cmd_rmw_i),
    .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i),
    .cmd_sel_i(cmd_sel_i),
    .rsp_valid_o(rsp_valid_o), .rsp_dat_o(rsp_dat_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i),
    .sel_o(sel_o), .we_o(we_o), .stb_o(stb_o),
    .cyc_o(cyc_o), .ack_i(ack_i), .err_i(err_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // ---- register-file slave ----
  logic [31:0] mem [16];
  bit          mem_init = 1'b1;
  bit          silent = 1'b0;
  bit          err_read = 1'b0;
  int          ack_hold = 0;
  int          hold_cnt;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      ack_i <= 1'b0;
      err_i <= 1'b0;
      dat_i <= '0;
      hold_cnt <= 0;
    end else if (cyc_o && stb_o && !ack_i && !err_i) begin
      if (silent) begin
        hold_cnt <= 0;
      end else if (err_read && !we_o) begin
        err_i <= 1'b1;
        hold_cnt <= ack_hold;
      end else begin
        ack_i <= 1'b1;
        hold_cnt <= ack_hold;
        dat_i <= mem[adr_o[3:0]];
        if (we_o)
          for (int b = 0; b < 4; b++)
            if (sel_o[b])
              mem[adr_o[3:0]][b*8 +: 8] <= dat_o[b*8 +: 8];
      end
    end else if (ack_i || err_i) begin
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      else begin
        ack_i <= 1'b0;
        err_i <= 1'b0;
      end
    end
  end

  // ---- behavioural model ----
  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        to;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] model_mem [16];
  logic [31:0] last_dat;

  function automatic logic [31:0] mrg(input logic [31:0] old,
                                      input logic [31:0] nw,
                                      input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  // ---- per-cycle compare process ----
  bit armed = 1'b0;
  bit prev_hs = 1'b0;
  bit prev_stb = 1'b0;
  bit prev_rsp = 1'b0;

  always @(negedge clk) begin
    if (armed && !rst_i) begin
      if (stb_o) chk("stb_without_cyc", cyc_o, 1);
      if (cyc_o) chk("ready_while_busy", cmd_ready_o, 0);
      if (prev_hs) chk("stb_after_ack", stb_o, 0);
      if (stb_o && !prev_stb)
        chk("stb_rise_on_ack", ack_i | err_i, 0);
      if (rsp_valid_o) begin
        chk("rsp_pulse_width", prev_rsp, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid_o, 0);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_dat", rsp_dat_o, e.dat);
          chk("rsp_err", rsp_err_o, e.err);
          chk("rsp_timeout", rsp_timeout_o, e.to);
        end
      end
    end
    prev_hs  = ack_i | err_i;
    prev_stb = stb_o;
    prev_rsp = rsp_valid_o;
  end

  // ---- command driver ----
  task automatic do_cmd(
    input  bit          we,
    input  bit          rmw,
    input  logic [15:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  bit          junk,
    output logic [31:0] rdat,
    output logic        rerr,
    output logic        rto,
    output int          lat,
    output int          rises,
    output int          gaps,
    output int          wr,
    output int          cyc_hi
  );
    rsp_t e;
    logic [3:0] ix;
    bit cyc_prev;
    bit done;
    ix = a[3:0];
    if (silent) begin
      e.dat = last_dat; e.err = 1'b1; e.to = 1'b1;
    end else if (err_read && (!we || rmw)) begin
      e.dat = last_dat; e.err = 1'b1; e.to = 1'b0;
    end else if (rmw) begin
      e.dat = model_mem[ix]; e.err = 1'b0; e.to = 1'b0;
      model_mem[ix] = mrg(model_mem[ix], d, s);
    end else if (we) begin
      e.dat = last_dat; e.err = 1'b0; e.to = 1'b0;
      model_mem[ix] = mrg(model_mem[ix], d, s);
    end else begin
      e.dat = model_mem[ix]; e.err = 1'b0; e.to = 1'b0;
    end
    last_dat = e.dat;
    exp_q.push_back(e);

    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_we_i = we; cmd_rmw_i = rmw;
    cmd_adr_i = a; cmd_dat_i = d; cmd_sel_i = s;
    for (int n = 0; n < 50 && !cmd_ready_o; n++) @(negedge clk);
    chk("cmd_accept", cmd_ready_o, 1);
    @(posedge clk);
    #1;
    cmd_valid_i = junk;
    cmd_we_i = 1'b1; cmd_rmw_i = 1'b0;
    cmd_adr_i = 16'h0007; cmd_dat_i = 32'h0; cmd_sel_i = 4'hF;

    rdat = 'x; rerr = 1'bx; rto = 1'bx;
    lat = 0; rises = 0; gaps = 0; wr = 0; cyc_hi = 0;
    cyc_prev = 1'b0;
    done = 1'b0;
    for (int n = 1; n <= 200 && !done; n++) begin
      @(negedge clk);
      if (cyc_o && !cyc_prev) rises++;
      if (cyc_o) cyc_hi++;
      if (cyc_o && !stb_o) gaps++;
      if (stb_o && we_o) wr++;
      cyc_prev = cyc_o;
      if (rsp_valid_o) begin
        rdat = rsp_dat_o; rerr = rsp_err_o; rto = rsp_timeout_o;
        lat = n;
        done = 1'b1;
        cmd_valid_i = 1'b0;
      end
    end
    cmd_valid_i = 1'b0;
    if (!done) chk("rsp_within_budget", done, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    exp_q.delete();
    last_dat = '0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got expired, expected done");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        re, rt;
  int          lat, rises, gaps, wr, chi;
  bit          found;
  int          held;

  initial begin
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_rmw_i = 1'b0;
    cmd_adr_i = '0; cmd_dat_i = '0; cmd_sel_i = '0;
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    last_dat = '0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_cyc", cyc_o, 0);
    chk("rst_stb", stb_o, 0);
    chk("rst_we", we_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_to", rsp_timeout_o, 0);
    chk("rst_adr_dat_sel", {adr_o, dat_o, sel_o}, 0);
    chk("rst_rsp_dat", rsp_dat_o, 0);
    rst_i = 1'b0;
    armed = 1'b1;

    // plain write then read back
    do_cmd(1, 0, 16'h0003, 32'hDEADBEEF, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("wr_err", re, 0);
    chk("wr_one_cyc", rises, 1);
    chk("wr_we_seen", wr > 0, 1);
    chk("wr_latency", lat, 4);
    do_cmd(0, 0, 16'h0003, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("rd_dat", rd, 32'hDEADBEEF);
    chk("rd_no_we", wr, 0);

    // read-modify-write low byte
    do_cmd(0, 1, 16'h0003, 32'h000000AA, 4'b0001, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("rmw_old", rd, 32'hDEADBEEF);
    chk("rmw_cyc_continuous", rises, 1);
    chk("rmw_gap", gaps >= 1, 1);
    chk("rmw_write_phase", wr > 0, 1);
    do_cmd(0, 0, 16'h0003, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("rmw_result", rd, 32'hDEADBEAA);

    // error on RMW read phase
    err_read = 1'b1;
    do_cmd(0, 1, 16'h0003, 32'h11111111, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    err_read = 1'b0;
    chk("err_flag", re, 1);
    chk("err_no_timeout", rt, 0);
    chk("err_no_write", wr, 0);
    do_cmd(0, 0, 16'h0003, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("err_reg_kept", rd, 32'hDEADBEAA);
    chk("err_cleared", re, 0);

    // partial-select write
    do_cmd(1, 0, 16'h0005, 32'h12345678, 4'b0110, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    do_cmd(0, 0, 16'h0005, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("partial_sel", rd, 32'h00345600);

    // slave holds ack; stray command while busy
    ack_hold = 3;
    do_cmd(1, 0, 16'h0007, 32'hCAFEF00D, 4'hF, 1,
           rd, re, rt, lat, rises, gaps, wr, chi);
    ack_hold = 0;
    chk("hold_latency", lat, 7);
    do_cmd(0, 0, 16'h0007, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("hold_readback", rd, 32'hCAFEF00D);

    // reset while in GAP of an RMW
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_rmw_i = 1'b1;
    cmd_adr_i = 16'h0003; cmd_dat_i = 32'hFF; cmd_sel_i = 4'h1;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (cyc_o && !stb_o) found = 1'b1;
    end
    chk("gap_reached", found, 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    last_dat = '0;
    chk("gap_rst_cyc", cyc_o, 0);
    chk("gap_rst_ready", cmd_ready_o, 1);
    chk("gap_rst_rsp_dat", rsp_dat_o, 0);
    repeat (5) @(negedge clk);
    do_cmd(0, 0, 16'h0003, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("after_rst_read", rd, 32'hDEADBEAA);

    // silent slave
`ifdef WB_MASTER_TIMEOUT_EN
    silent = 1'b1;
    do_cmd(0, 0, 16'h0009, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    silent = 1'b0;
    chk("to_cyc_cycles", chi, 8);
    chk("to_err", re, 1);
    chk("to_flag", rt, 1);
`else
    silent = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_rmw_i = 1'b0;
    cmd_adr_i = 16'h0009; cmd_sel_i = 4'hF;
    @(posedge clk);
    #1 cmd_valid_i = 1'b0;
    held = 0;
    for (int n = 0; n < 120; n++) begin
      @(negedge clk);
      if (cyc_o && stb_o) held++;
    end
    chk("no_to_cyc_held", held, 120);
    chk("no_to_flag", rsp_timeout_o, 0);
    silent = 1'b0;
    do_reset();
`endif
    do_cmd(0, 0, 16'h0007, 32'h0, 4'hF, 0,
           rd, re, rt, lat, rises, gaps, wr, chi);
    chk("final_read", rd, 32'hCAFEF00D);
    chk("final_to_clear", rt, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_master_single.md
WB_MASTER_SINGLE -- requirements
Module: wb_master_single

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 16, address bits; DATA_WIDTH, default 32, port size (8/16/32/64); GRANULE, default 8, select granularity; TIMEOUT_CYCLES, default 255, watchdog limit; SEL_WIDTH = DATA_WIDTH/GRANULE (localparam).
REQ-002 SHALL have one clock and a synchronous active-high reset; ports are listed below, clock and reset first.
REQ-003 clk_i  in  1  clock, all logic on rising edge.
REQ-004 rst_i  in  1  synchronous active-high reset.
REQ-005 cmd_valid_i  in  1  command offered; cmd_ready_o  out  1  command accepted when both high.
REQ-006 cmd_we_i  in  1  write; cmd_rmw_i  in  1  read-modify-write, overrides cmd_we_i; cmd_adr_i  in  ADDR_WIDTH; cmd_dat_i  in  DATA_WIDTH; cmd_sel_i  in  SEL_WIDTH.
REQ-007 rsp_valid_o  out  1  one-cycle completion pulse; rsp_dat_o  out  DATA_WIDTH  read data; rsp_err_o  out  1  error; rsp_timeout_o  out  1  watchdog abort.
REQ-008 Wishbone B4 master side: adr_o  out  ADDR_WIDTH; dat_o  out  DATA_WIDTH; dat_i  in  DATA_WIDTH; sel_o  out  SEL_WIDTH; we_o  out  1; stb_o  out  1; cyc_o  out  1; ack_i  in  1; err_i  in  1.

Function
REQ-009 FSM states SHALL be IDLE, BUS, GAP, DRAIN, RESP; all outputs registered.
REQ-010 IDLE: cmd_ready_o=1, cyc_o=stb_o=0; on cmd_valid_i capture adr/dat/sel/we/rmw, go BUS with cyc_o=stb_o=1, we_o=cmd_we_i&~cmd_rmw_i.
REQ-011 BUS: adr_o/sel_o/we_o/dat_o held stable; wait for ack_i or err_i; err_i takes priority when both high.
REQ-012 BUS on err_i: cyc_o=stb_o=0, rsp_err_o=1, go DRAIN; on an RMW, the write phase is skipped.
REQ-013 BUS on ack_i, plain read: latch dat_i into rsp_dat_o; plain write: rsp_dat_o unchanged; cyc_o=stb_o=0, go DRAIN.
REQ-014 BUS on ack_i, RMW read phase: per granule i, merged = sel[i] ? cmd_dat : dat_i; rsp_dat_o = dat_i (old value); stb_o=0, cyc_o stays 1, go GAP.
REQ-015 GAP: when ack_i=0 and err_i=0, drive dat_o=merged, we_o=1, stb_o=1, go BUS (write phase); cyc_o SHALL NOT drop between phases.
REQ-016 DRAIN: cyc_o=stb_o=0; when ack_i=0 and err_i=0, go RESP; no new STB while slave ack/err is still high.
REQ-017 RESP: rsp_valid_o=1 for exactly one cycle, then IDLE; rsp_dat_o/rsp_err_o/rsp_timeout_o hold until next acceptance.
REQ-018 stb_o SHALL be low for at least one cycle after every ack_i/err_i; one outstanding transfer only (no pipelining).
REQ-019 cmd_* ignored when cmd_ready_o=0; rsp_err_o and rsp_timeout_o cleared on command acceptance.

Reset
REQ-020 rst_i at any state, including mid-cycle, SHALL next cycle force IDLE, cyc_o=stb_o=we_o=0, rsp_valid_o=rsp_err_o=rsp_timeout_o=0, cmd_ready_o=1, adr_o/dat_o/sel_o/rsp_dat_o=0, and watchdog=0.
REQ-021 An in-flight command aborted by reset SHALL produce no rsp_valid_o.

Configuration
REQ-022 With WB_MASTER_TIMEOUT_EN defined: watchdog counts cycles in BUS (reset on each BUS entry); reaching TIMEOUT_CYCLES without ack_i/err_i drops cyc_o/stb_o, sets rsp_err_o=rsp_timeout_o=1, goes DRAIN.
REQ-023 Without WB_MASTER_TIMEOUT_EN: no counter logic; rsp_timeout_o tied 0; BUS waits indefinitely.

Structure
REQ-024 Package wb_pkg SHALL hold the FSM enum typedef (wbm_state_t) and the default width constants; no typedef at compilation-unit scope.
REQ-025 Watchdog SHALL be sub-module wb_watchdog (clear, enable, expired; width $clog2(TIMEOUT_CYCLES+1)), instantiated only under WB_MASTER_TIMEOUT_EN.

Verification
REQ-026 Write adr 0x0003, dat 0xDEADBEEF, sel 4'hF to a register slave model -> one CYC, we_o=1, rsp_valid_o once, rsp_err_o=0; read back -> rsp_dat_o=0xDEADBEEF.
REQ-027 RMW adr 0x0003, dat 0x000000AA, sel 4'b0001 over 0xDEADBEEF -> cyc_o continuous, stb_o low one or more cycles between phases, rsp_dat_o=0xDEADBEEF, then read gives 0xDEADBEAA.
REQ-028 Slave asserts err_i on read phase of RMW -> no write phase, rsp_err_o=1, rsp_timeout_o=0, register unchanged.
REQ-029 Silent slave with WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8 -> cyc_o drops after 8 BUS cycles, rsp_err_o=rsp_timeout_o=1; without macro, cyc_o held 100+ cycles.
REQ-030 rst_i pulsed in GAP -> next cycle cyc_o=0, cmd_ready_o=1, no rsp_valid_o; following command completes normally.
REQ-031 Slave holding ack_i high 3 cycles after stb_o falls -> DRAIN holds, rsp_valid_o delayed, next stb_o only after ack_i low.
